// File: rtl/serial_adder.sv
// Bit-serial adder: computes A + B + CIN one bit per clock, LSB first, using a single carry flop.
// Operands enter and results leave through valid/ready handshakes.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
    output logic             BUSY
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             out_valid_q;
    logic             busy_q;

    // Full adder built from two half-adder cells and an OR.
    logic ha1_s, ha1_c, ha2_s, ha2_c, bit_c;
    assign ha1_s = sa_q[0] ^ sb_q[0];
    assign ha1_c = sa_q[0] & sb_q[0];
    assign ha2_s = ha1_s ^ c_q;
    assign ha2_c = ha1_s & c_q;
    assign bit_c = ha1_c | ha2_c;

    // Result bits shift into the top of SA as its operand bits drain out of the bottom,
    // so SA doubles as the result shift register.
    logic [WIDTH-1:0] sr_d;
    assign sr_d = {ha2_s, sa_q[WIDTH-1:1]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            sa_q        <= '0;
            sb_q        <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (IN_VALID) begin
                        sa_q    <= A;
                        sb_q    <= B;
                        c_q     <= CIN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sa_q  <= sr_d;
                    sb_q  <= {1'b0, sb_q[WIDTH-1:1]};
                    c_q   <= bit_c;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        cnt_q       <= '0;
                        sum_q       <= sr_d;
                        carry_q     <= bit_c;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign IN_READY  = (state_q == IDLE) & ~RST;
    assign OUT_VALID = out_valid_q;
    assign SUM       = sum_q;
    assign CARRY     = carry_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks of serial_adder (WIDTH=8): latency, wrap, backpressure,
// back-to-back issue, mid-operation reset.
module tb_serial_adder;

    localparam int unsigned WIDTH = 8;

    logic             CLK = 1'b0;
    logic             RST;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] SUM;
    logic             CARRY;
    logic             BUSY;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .CIN       (CIN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .SUM       (SUM),
        .CARRY     (CARRY),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!IN_READY && n < 50) begin
            step();
            n++;
        end
        if (!IN_READY) check("in_ready_timeout", 32'(IN_READY), 32'd1);
    endtask

    // Issue one operation, wait for its result, compare, then consume it.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic ci, input logic [8:0] exp);
        int n = 0;
        wait_ready();
        A = a; B = b; CIN = ci; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        A = ~a; B = 8'($urandom); CIN = ~ci;
        while (!OUT_VALID && n < 30) begin
            step();
            n++;
        end
        check({tag, "_valid"}, 32'(OUT_VALID), 32'd1);
        check(tag, 32'({CARRY, SUM}), 32'(exp));
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
    endtask

    initial begin
        int t0, t1, n, acc, outs;
        logic prev_busy, got1, seen, done;
        logic [8:0] r1, r2, exp;
        logic [7:0] ra, rb;
        logic rc;

        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; A = '0; B = '0; CIN = 1'b0;
        #12;
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_sum",       32'(SUM),       32'd0);
        check("rst_carry",     32'(CARRY),     32'd0);
        check("rst_busy",      32'(BUSY),      32'd0);
        check("rst_in_ready",  32'(IN_READY),  32'd0);
        @(negedge CLK) RST = 1'b0;
        step();
        check("post_rst_in_ready", 32'(IN_READY), 32'd1);

        // Basic 0x0F + 0x01 with cycle-exact latency.
        A = 8'h0F; B = 8'h01; CIN = 1'b0; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0; A = 8'hFF; B = 8'hFF; CIN = 1'b1;
        check("basic_busy_start", 32'(BUSY), 32'd1);
        check("basic_in_ready",   32'(IN_READY), 32'd0);
        for (int i = 1; i < 8; i++) begin
            step();
            check("basic_busy_run",  32'(BUSY), 32'd1);
            check("basic_no_valid",  32'(OUT_VALID), 32'd0);
        end
        step();
        check("basic_valid", 32'(OUT_VALID), 32'd1);
        check("basic_busy_done", 32'(BUSY), 32'd0);
        check("basic_result", 32'({CARRY, SUM}), 32'h010);

        // Backpressure: DONE holds while new operands are offered.
        A = 8'h33; B = 8'h44; CIN = 1'b1; IN_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid",    32'(OUT_VALID), 32'd1);
            check("bp_result",   32'({CARRY, SUM}), 32'h010);
            check("bp_in_ready", 32'(IN_READY), 32'd0);
        end
        OUT_READY = 1'b1; IN_VALID = 1'b0;
        step();
        OUT_READY = 1'b0;
        check("bp_valid_drop", 32'(OUT_VALID), 32'd0);
        check("bp_idle_ready", 32'(IN_READY), 32'd1);
        check("bp_not_taken",  32'(BUSY), 32'd0);
        run_op("bp_new", 8'h33, 8'h44, 1'b1, 9'h078);

        run_op("zero_cin", 8'h00, 8'h00, 1'b1, 9'h001);
        run_op("wrap_ff01", 8'hFF, 8'h01, 1'b0, 9'h100);
        run_op("wrap_ffff", 8'hFF, 8'hFF, 1'b1, 9'h1FF);

        // Reset three cycles into an operation.
        wait_ready();
        A = 8'h55; B = 8'h2A; CIN = 1'b0; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        step(); step(); step();
        check("mid_busy", 32'(BUSY), 32'd1);
        #2 RST = 1'b1;
        #1;
        check("mid_rst_valid", 32'(OUT_VALID), 32'd0);
        check("mid_rst_sum",   32'(SUM),       32'd0);
        check("mid_rst_carry", 32'(CARRY),     32'd0);
        check("mid_rst_busy",  32'(BUSY),      32'd0);
        check("mid_rst_ready", 32'(IN_READY),  32'd0);
        @(negedge CLK) RST = 1'b0;
        step();
        check("mid_rel_ready", 32'(IN_READY), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            seen |= OUT_VALID | BUSY;
        end
        check("mid_no_result", 32'(seen), 32'd0);

        // Back-to-back issue with IN_VALID/OUT_READY held high.
        A = 8'h12; B = 8'h34; CIN = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
        step();
        t0 = cyc; t1 = cyc;
        A = 8'hC8; B = 8'h64; CIN = 1'b1;
        prev_busy = BUSY; got1 = 1'b0; r1 = '0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (OUT_VALID) begin
                r1 = {CARRY, SUM};
                got1 = 1'b1;
            end
            if (BUSY && !prev_busy) begin
                t1 = cyc;
                break;
            end
            prev_busy = BUSY;
        end
        IN_VALID = 1'b0;
        check("b2b_got1", 32'(got1), 32'd1);
        check("b2b_r1", 32'(r1), 32'h046);
        check("b2b_interval", 32'(t1 - t0), 32'd10);
        n = 0;
        while (!OUT_VALID && n < 30) begin
            step();
            n++;
        end
        r2 = {CARRY, SUM};
        check("b2b_valid2", 32'(OUT_VALID), 32'd1);
        check("b2b_r2", 32'(r2), 32'h12D);
        step();
        OUT_READY = 1'b0;

        // Random operands with random output stalls.
        acc = 0; outs = 0;
        for (int k = 0; k < 1000; k++) begin
            wait_ready();
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp = 9'(ra) + 9'(rb) + 9'(rc);
            A = ra; B = rb; CIN = rc; IN_VALID = 1'b1;
            step();
            acc++;
            IN_VALID = 1'b0;
            A = 8'($urandom); B = 8'($urandom); CIN = 1'($urandom);
            done = 1'b0; seen = 1'b0; n = 0;
            while (!done && n < 200) begin
                OUT_READY = ($urandom_range(0, 3) == 0);
                if (OUT_VALID && !seen) begin
                    seen = 1'b1;
                    outs++;
                    check("rand_result", 32'({CARRY, SUM}), 32'(exp));
                end
                if (OUT_VALID && OUT_READY) done = 1'b1;
                step();
                n++;
            end
            OUT_READY = 1'b0;
            if (!done) check("rand_timeout", 32'(done), 32'd1);
        end
        check("rand_count", 32'(outs), 32'(acc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder that computes A + B + CIN over WIDTH clock cycles using one carry flop.
- Each bit is formed by two half-adder cells plus an OR (full-adder equivalent), evaluated LSB-first.
- Sits on the datapath where operand pairs arrive and results leave through valid/ready handshakes.
- Trades throughput for area.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range is 2 or more.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge
- RST  input  1  asynchronous, active-high reset
- IN_VALID  input  1  operand pair A/B/CIN is presented
- IN_READY  output  1  block can accept operands
- A  input  WIDTH  first operand
- B  input  WIDTH  second operand
- CIN  input  1  carry-in
- OUT_VALID  output  1  SUM/CARRY hold a completed result
- OUT_READY  input  1  downstream accepts result
- SUM  output  WIDTH  result bits, A+B+CIN modulo 2^WIDTH
- CARRY  output  1  carry-out of the MSB
- BUSY  output  1  high while a computation is in progress (RUN state)

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-high on RST.
- Reset values, applied immediately when RST asserts: state IDLE, OUT_VALID 0, SUM 0, CARRY 0, BUSY 0, internal shift registers/carry/counter 0.
- IN_READY = (state==IDLE) & ~RST, so it reads 0 while RST is high.
- An operation in flight when RST asserts is discarded. No OUT_VALID is produced for it.
- FSM states:
  - IDLE
    - IN_READY=1.
    - On IN_VALID&IN_READY: latch A into shift reg SA, B into SB; carry reg C <= CIN; bit counter CNT <= 0; go to RUN.
    - A/B/CIN are sampled only on that edge.
  - RUN
    - BUSY=1, IN_READY=0.
    - Each edge: s = SA[0]^SB[0]^C.
    - C <= (SA[0]&SB[0]) | (C&(SA[0]^SB[0])).
    - s shifts into the MSB of result shift reg SR (right shift).
    - SA and SB shift right.
    - CNT increments.
    - On the edge where CNT==WIDTH-1: SUM <= final SR value including that edge's bit; CARRY <= final carry; go to DONE.
  - DONE
    - OUT_VALID=1; SUM/CARRY stable.
    - On OUT_READY: go to IDLE, and OUT_VALID drops the next cycle.
    - While OUT_READY=0, hold indefinitely with no change to any output. IN_VALID is ignored.
- SUM and CARRY are output registers. They update only on the RUN->DONE transition and retain the last result in IDLE/RUN (0 after reset).
- Timing:
  - Latency: operands accepted on edge k cause OUT_VALID=1 starting after edge k+WIDTH.
  - Minimum issue interval with OUT_READY tied high: WIDTH+2 cycles (accept, WIDTH RUN edges, DONE handshake edge).
- Arithmetic: full WIDTH+1-bit result = {CARRY,SUM}. No overflow flag; the wrap is carried in CARRY.
- CNT width: $clog2(WIDTH). CNT never exceeds WIDTH-1.
- Simultaneous events:
  - IN_VALID asserted in DONE is not accepted, even if OUT_READY=1 on that edge.
  - Acceptance occurs only from IDLE.
- Changes on A/B/CIN after acceptance have no effect on the result in flight.

Test Plan (WIDTH=8):
- Reset: assert RST mid-RUN, 3 cycles after accepting A=0x55,B=0x2A -> OUT_VALID, SUM, CARRY, BUSY read 0 immediately (asynchronously); IN_READY=1 one cycle after release; no result ever appears for that operation.
- Basic: accept A=0x0F, B=0x01, CIN=0 at edge k -> BUSY high 8 cycles; OUT_VALID=1 after edge k+8 with SUM=0x10, CARRY=0.
- Wrap: A=0xFF, B=0x01, CIN=0 -> SUM=0x00, CARRY=1. Also A=0xFF, B=0xFF, CIN=1 -> SUM=0xFF, CARRY=1. Also A=0, B=0, CIN=1 -> SUM=0x01, CARRY=0.
- Backpressure: hold OUT_READY=0 for 5 cycles in DONE while driving IN_VALID=1 with new operands -> OUT_VALID stays 1, SUM/CARRY unchanged, IN_READY=0, new operands not accepted. Raise OUT_READY -> IDLE next cycle, then new operands accepted.
- Back-to-back: IN_VALID and OUT_READY held high with two operand pairs -> second acceptance exactly WIDTH+2 edges after first; both results correct.
- Random: 1000 random A/B/CIN with random OUT_READY stalls -> every {CARRY,SUM} equals A+B+CIN; OUT_VALID count equals accepted-operation count.
